player_pos_ctl: RTL and testbench
=================================

// Module: player_pos_ctl
// PURPOSE
//  Parametrised player-sprite position controller for the labyrinth game; successor to fixed-map control.
//  Steps the sprite on debounced arrow keys at a programmable rate, clamped to the play field.
//  Blocks moves into N_OBST static rectangles (packed bus); respawns on contact with the moving obstacle.
//  Latches goal arrival (enables mouse stage) and counts hits; sits between keyboard decoder and draw_player.
// PARAMETERS
//  X_MIN 1 / X_MAX 699    : legal xpos range (top-left corner of sprite)
//  Y_MIN 1 / Y_MAX 499    : legal ypos range
//  START_X 1 / START_Y 1  : spawn / respawn position
//  SPR_W 100 / SPR_H 100  : player sprite size, px
//  DYN_W 50 / DYN_H 250   : moving-obstacle size, px
//  N_OBST 3               : number of static obstacle rectangles, 1..8
//  STEP 1                 : px moved per move tick, 1..15
//  RATE_DIV 1             : clocks per move tick, >=1 (1 = every clock)
//  RESPAWN_CYC 16         : clocks spent in HIT before play resumes, >=1
//  GOAL_X0 750, GOAL_Y0 200, GOAL_Y1 400 : goal zone; right edge open
//  LIVES 3                : starting lives (LIVES_EN only), 1..15
// PORTS
//  clk         in   1            system clock
//  rst         in   1            synchronous active-high reset
//  keys        in   4            {up,down,right,left}, level, 1 = held
//  obst_rects  in   N_OBST*48    rect i at [48i+:48] = {x0,y0,x1,y1}, 12b each; x1>x0, y1>y0; solid region x0<=x<x1, y0<=y<y1
//  dyn_x/dyn_y in   12/12        moving obstacle top-left, may change any cycle
//  xpos/ypos   out  12/12        sprite top-left, registered
//  state       out  2            0 PLAY, 1 HIT, 2 GOAL, 3 OVER
//  mouse_en    out  1            1 while state==GOAL
//  hit_pulse   out  1            1-cycle pulse on each HIT entry
//  hit_cnt     out  8            hits since reset, saturates at 255
//  game_over   out  1            1 while state==OVER
// BEHAVIOUR
//  Reset: xpos=START_X, ypos=START_Y, state=PLAY, rate cnt=0, outs 0, hit_cnt=0, lives=LIVES.
//  Rate counter 0..RATE_DIV-1 free-runs in PLAY; move tick when cnt==RATE_DIV-1; cleared outside PLAY.
//  Key priority up>down>right>left; one axis per tick; no key -> hold.
//  Candidate: pos +/- STEP computed in 13b signed; clamped to [X_MIN,X_MAX]/[Y_MIN,Y_MAX] (no wrap).
//  Static block: candidate rejected (pos held) if sprite at candidate overlaps any obst rect:
//   cx<x1 && cx+SPR_W>x0 && cy<y1 && cy+SPR_H>y0 (13b compare, no overflow).
//  Dynamic hit: checked every PLAY cycle on current registered pos vs {dyn_x,dyn_y,DYN_W,DYN_H}, same
//   overlap rule. Next cycle: state=HIT, pos=START, hit_pulse=1, hit_cnt+=1 (sat).
//  HIT: keys ignored; after RESPAWN_CYC cycles -> PLAY. Dyn overlap at spawn during HIT is ignored.
//  Goal: in PLAY, xpos+SPR_W>GOAL_X0 && ypos>GOAL_Y0 && ypos+SPR_H<GOAL_Y1 -> GOAL next cycle.
//  GOAL is sticky until rst; pos frozen; mouse_en=1.
//  Same-cycle hit and goal: hit wins. Same-cycle tick and hit: hit wins, move discarded.
//  rst mid-move / mid-HIT: all state restored to reset values next edge; no residual pulse.
//  Outputs registered; key-to-xpos/ypos latency = 1 clock after the tick edge.
// CONFIGURATION
//  PLAYER_LIVES_EN defined: 4b lives counter, decremented on each HIT entry; a hit that takes lives
//   to 0 -> OVER instead of HIT (hit_pulse/hit_cnt still update); OVER sticky until rst,
//   pos frozen, game_over=1.
//  Undefined: no lives logic; OVER unreachable; game_over tied 0; hits always respawn.
// TESTING
//  rst, RATE_DIV=4, keys=right held 40 clk -> xpos 1->11, one step per 4 clk, ypos 1.
//  xpos=X_MAX, keys=right -> xpos stays 699; ypos=Y_MIN, keys=up -> stays 1.
//  Rect {200,0,300,200}, pos (99,50), right held -> xpos stops at 100 (cand 101 overlaps).
//  Dyn at (150,1), player walks right into it -> state HIT, hit_pulse 1 clk, pos (1,1), hit_cnt 1,
//   PLAY after 16 clk.
//  Pos (660,250) -> state GOAL, mouse_en=1; keys then ignored; rst -> PLAY, (1,1), mouse_en 0.
//  PLAYER_LIVES_EN, LIVES=2: two hits -> 2nd gives OVER, game_over=1, hit_cnt 2, pos frozen.

Source files
------------

// File: rtl/player_pos_ctl.sv
// Player-sprite position controller: rate-limited key stepping, play-field clamp, static-obstacle
// blocking, moving-obstacle respawn, sticky goal latch. Optional lives/game-over: `PLAYER_LIVES_EN.
module player_pos_ctl #(
    parameter int X_MIN       = 1,
    parameter int X_MAX       = 699,
    parameter int Y_MIN       = 1,
    parameter int Y_MAX       = 499,
    parameter int START_X     = 1,
    parameter int START_Y     = 1,
    parameter int SPR_W       = 100,
    parameter int SPR_H       = 100,
    parameter int DYN_W       = 50,
    parameter int DYN_H       = 250,
    parameter int N_OBST      = 3,
    parameter int STEP        = 1,
    parameter int RATE_DIV    = 1,
    parameter int RESPAWN_CYC = 16,
    parameter int GOAL_X0     = 750,
    parameter int GOAL_Y0     = 200,
    parameter int GOAL_Y1     = 400
`ifdef PLAYER_LIVES_EN
    ,
    parameter int LIVES       = 3
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            keys,
    input  logic [N_OBST*48-1:0]  obst_rects,
    input  logic [11:0]           dyn_x,
    input  logic [11:0]           dyn_y,
    output logic [11:0]           xpos,
    output logic [11:0]           ypos,
    output logic [1:0]            state,
    output logic                  mouse_en,
    output logic                  hit_pulse,
    output logic [7:0]            hit_cnt,
    output logic                  game_over
);

    typedef enum logic [1:0] {
        ST_PLAY = 2'd0,
        ST_HIT  = 2'd1,
        ST_GOAL = 2'd2,
        ST_OVER = 2'd3
    } state_t;

    localparam int CNT_W = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
    localparam int RSP_W = (RESPAWN_CYC > 1) ? $clog2(RESPAWN_CYC) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(RATE_DIV - 1);
    localparam logic [RSP_W-1:0]  RSP_LAST = RSP_W'(RESPAWN_CYC - 1);
    localparam logic signed [12:0] STEP_S  = 13'(STEP);
    localparam logic signed [12:0] XMIN_S  = 13'(X_MIN);
    localparam logic signed [12:0] XMAX_S  = 13'(X_MAX);
    localparam logic signed [12:0] YMIN_S  = 13'(Y_MIN);
    localparam logic signed [12:0] YMAX_S  = 13'(Y_MAX);

    // Rectangle overlap of the sprite at (ax,ay); 14b so far-right rects cannot wrap.
    function automatic logic overlap(input logic [13:0] ax, input logic [13:0] ay,
                                     input logic [13:0] bx0, input logic [13:0] by0,
                                     input logic [13:0] bx1, input logic [13:0] by1);
        return (ax < bx1) && (ax + 14'(SPR_W) > bx0) && (ay < by1) && (ay + 14'(SPR_H) > by0);
    endfunction

    state_t             r_state, w_state_nx;
    logic [11:0]        r_xpos, r_ypos, w_x_nx, w_y_nx;
    logic [CNT_W-1:0]   r_rate_cnt, w_rate_nx;
    logic [RSP_W-1:0]   r_rsp_cnt, w_rsp_nx;
    logic [7:0]         r_hit_cnt, w_hcnt_nx;
    logic               r_hit_pulse, w_pulse_nx;
    logic               r_mouse_en, r_game_over;
`ifdef PLAYER_LIVES_EN
    logic [3:0]         r_lives, w_lives_nx;
`endif

    logic signed [12:0] w_dx, w_dy, w_cand_x, w_cand_y;
    logic [11:0]        w_clamp_x, w_clamp_y;
    logic               w_move, w_blocked, w_dyn_hit, w_goal, w_tick;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_dx   = '0;
        w_dy   = '0;
        w_move = 1'b1;
        if (keys[3])      w_dy = -STEP_S;
        else if (keys[2]) w_dy = STEP_S;
        else if (keys[1]) w_dx = STEP_S;
        else if (keys[0]) w_dx = -STEP_S;
        else              w_move = 1'b0;

        w_cand_x  = $signed({1'b0, r_xpos}) + w_dx;
        w_cand_y  = $signed({1'b0, r_ypos}) + w_dy;
        w_clamp_x = (w_cand_x < XMIN_S) ? 12'(X_MIN) :
                    (w_cand_x > XMAX_S) ? 12'(X_MAX) : w_cand_x[11:0];
        w_clamp_y = (w_cand_y < YMIN_S) ? 12'(Y_MIN) :
                    (w_cand_y > YMAX_S) ? 12'(Y_MAX) : w_cand_y[11:0];

        w_blocked = 1'b0;
        for (int i = 0; i < N_OBST; i++) begin
            if (overlap({2'b0, w_clamp_x}, {2'b0, w_clamp_y},
                        {2'b0, obst_rects[48*i+36 +: 12]}, {2'b0, obst_rects[48*i+24 +: 12]},
                        {2'b0, obst_rects[48*i+12 +: 12]}, {2'b0, obst_rects[48*i +: 12]}))
                w_blocked = 1'b1;
        end
    end

    assign w_dyn_hit = overlap({2'b0, r_xpos}, {2'b0, r_ypos}, {2'b0, dyn_x}, {2'b0, dyn_y},
                               {2'b0, dyn_x} + 14'(DYN_W), {2'b0, dyn_y} + 14'(DYN_H));
    assign w_goal    = ({2'b0, r_xpos} + 14'(SPR_W) > 14'(GOAL_X0)) && (r_ypos > 12'(GOAL_Y0)) &&
                       ({2'b0, r_ypos} + 14'(SPR_H) < 14'(GOAL_Y1));
    assign w_tick    = (r_state == ST_PLAY) && (r_rate_cnt == CNT_LAST);

    always_comb begin
        w_state_nx = r_state;
        w_x_nx     = r_xpos;
        w_y_nx     = r_ypos;
        w_rate_nx  = '0;
        w_rsp_nx   = '0;
        w_pulse_nx = 1'b0;
        w_hcnt_nx  = r_hit_cnt;
`ifdef PLAYER_LIVES_EN
        w_lives_nx = r_lives;
`endif
        case (r_state)
            ST_PLAY: begin
                w_rate_nx = w_tick ? '0 : r_rate_cnt + 1'b1;
                if (w_dyn_hit) begin
                    // Hit outranks both goal arrival and a pending move.
                    w_rate_nx  = '0;
                    w_pulse_nx = 1'b1;
                    w_hcnt_nx  = (r_hit_cnt == 8'hFF) ? r_hit_cnt : r_hit_cnt + 8'd1;
`ifdef PLAYER_LIVES_EN
                    if (r_lives == 4'd1) begin
                        w_lives_nx = 4'd0;
                        w_state_nx = ST_OVER;
                    end else begin
                        w_lives_nx = r_lives - 4'd1;
                        w_state_nx = ST_HIT;
                        w_x_nx     = 12'(START_X);
                        w_y_nx     = 12'(START_Y);
                    end
`else
                    w_state_nx = ST_HIT;
                    w_x_nx     = 12'(START_X);
                    w_y_nx     = 12'(START_Y);
`endif
                end else if (w_goal) begin
                    w_rate_nx  = '0;
                    w_state_nx = ST_GOAL;
                end else if (w_tick && w_move && !w_blocked) begin
                    w_x_nx = w_clamp_x;
                    w_y_nx = w_clamp_y;
                end
            end
            ST_HIT: begin
                if (r_rsp_cnt == RSP_LAST) w_state_nx = ST_PLAY;
                else                       w_rsp_nx   = r_rsp_cnt + 1'b1;
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_PLAY;
            r_xpos      <= 12'(START_X);
            r_ypos      <= 12'(START_Y);
            r_rate_cnt  <= '0;
            r_rsp_cnt   <= '0;
            r_hit_cnt   <= '0;
            r_hit_pulse <= 1'b0;
            r_mouse_en  <= 1'b0;
            r_game_over <= 1'b0;
`ifdef PLAYER_LIVES_EN
            r_lives     <= 4'(LIVES);
`endif
        end else begin
            r_state     <= w_state_nx;
            r_xpos      <= w_x_nx;
            r_ypos      <= w_y_nx;
            r_rate_cnt  <= w_rate_nx;
            r_rsp_cnt   <= w_rsp_nx;
            r_hit_cnt   <= w_hcnt_nx;
            r_hit_pulse <= w_pulse_nx;
            r_mouse_en  <= (w_state_nx == ST_GOAL);
            r_game_over <= (w_state_nx == ST_OVER);
`ifdef PLAYER_LIVES_EN
            r_lives     <= w_lives_nx;
`endif
        end
    end

    assign xpos      = r_xpos;
    assign ypos      = r_ypos;
    assign state     = r_state;
    assign mouse_en  = r_mouse_en;
    assign hit_pulse = r_hit_pulse;
    assign hit_cnt   = r_hit_cnt;
`ifdef PLAYER_LIVES_EN
    assign game_over = r_game_over;
`else
    assign game_over = 1'b0;
`endif

endmodule

// File: tb/tb_player_pos_ctl.sv
// Directed bench for player_pos_ctl (RATE_DIV=4): vector table for stepping/clamp/priority,
// hand sequences for blocking, hit/respawn, reset, goal, and lives (PLAYER_LIVES_EN) or saturation.
module tb_player_pos_ctl;

    localparam int N_OBST = 3;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [3:0]           keys;
    logic [N_OBST*48-1:0] obst_rects;
    logic [11:0]          dyn_x, dyn_y;
    logic [11:0]          xpos, ypos;
    logic [1:0]           state;
    logic                 mouse_en, hit_pulse, game_over;
    logic [7:0]           hit_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    player_pos_ctl #(
        .RATE_DIV    (4),
        .N_OBST      (N_OBST),
        .STEP        (1),
        .RESPAWN_CYC (16)
`ifdef PLAYER_LIVES_EN
        ,
        .LIVES       (2)
`endif
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .keys       (keys),
        .obst_rects (obst_rects),
        .dyn_x      (dyn_x),
        .dyn_y      (dyn_y),
        .xpos       (xpos),
        .ypos       (ypos),
        .state      (state),
        .mouse_en   (mouse_en),
        .hit_pulse  (hit_pulse),
        .hit_cnt    (hit_cnt),
        .game_over  (game_over)
    );

    typedef struct {
        logic [3:0]  keys;
        int          cycles;
        logic [11:0] x;
        logic [11:0] y;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    localparam logic [3:0] K_NONE = 4'b0000, K_UP = 4'b1000, K_DOWN = 4'b0100,
                           K_RIGHT = 4'b0010, K_LEFT = 4'b0001;

    function automatic logic [47:0] rect(input int x0, input int y0, input int x1, input int y1);
        return {12'(x0), 12'(y0), 12'(x1), 12'(y1)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
        end
    endtask

    task automatic check_pos(input string name, input int x, input int y);
        check({name, " xpos"}, 32'(xpos), 32'(x));
        check({name, " ypos"}, 32'(ypos), 32'(y));
    endtask

    // Advance n rising edges; returns on a falling edge where inputs are driven and outputs sampled.
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic far_away();
        obst_rects = {rect(4000, 4000, 4050, 4050), rect(4000, 4000, 4050, 4050),
                      rect(4000, 4000, 4050, 4050)};
        dyn_x = 12'd4000;
        dyn_y = 12'd4000;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        keys = K_NONE;
        step(2);
        rst  = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{K_NONE,  4,    12'd1,   12'd1};
        vecs[1]  = '{K_RIGHT, 40,   12'd11,  12'd1};
        vecs[2]  = '{K_UP,    8,    12'd11,  12'd1};
        vecs[3]  = '{K_LEFT,  8,    12'd9,   12'd1};
        vecs[4]  = '{K_DOWN,  8,    12'd9,   12'd3};
        vecs[5]  = '{4'b1100, 8,    12'd9,   12'd1};
        vecs[6]  = '{4'b0011, 4,    12'd10,  12'd1};
        vecs[7]  = '{4'b0110, 4,    12'd10,  12'd2};
        vecs[8]  = '{K_LEFT,  40,   12'd1,   12'd2};
        vecs[9]  = '{K_RIGHT, 2800, 12'd699, 12'd2};
        vecs[10] = '{K_UP,    8,    12'd699, 12'd1};
        vecs[11] = '{K_LEFT,  3,    12'd699, 12'd1};
        vecs[12] = '{K_LEFT,  1,    12'd698, 12'd1};
        vecs[13] = '{4'b0111, 4,    12'd698, 12'd2};
        vecs[14] = '{K_NONE,  12,   12'd698, 12'd2};

        far_away();
        do_reset();
        check_pos("reset", 1, 1);
        check("reset state", 32'(state), 0);
        check("reset mouse_en", 32'(mouse_en), 0);
        check("reset hit_pulse", 32'(hit_pulse), 0);
        check("reset hit_cnt", 32'(hit_cnt), 0);
        check("reset game_over", 32'(game_over), 0);

        for (int i = 0; i < NV; i++) begin
            keys = vecs[i].keys;
            step(vecs[i].cycles);
            check_pos($sformatf("vec%0d", i), int'(vecs[i].x), int'(vecs[i].y));
            check($sformatf("vec%0d state", i), 32'(state), 0);
        end

        // Static rectangle in the middle slot blocks the rightward walk at x=100.
        far_away();
        obst_rects[48 +: 48] = rect(200, 0, 300, 200);
        do_reset();
        keys = K_DOWN;
        step(196);
        check_pos("block approach", 1, 50);
        keys = K_RIGHT;
        step(400);
        check_pos("block stop", 100, 50);
        keys = K_LEFT;
        step(4);
        check_pos("block back off", 99, 50);

        // Walk into the moving obstacle, respawn, ignore spawn overlap during HIT.
        far_away();
        dyn_x = 12'd150;
        dyn_y = 12'd1;
        do_reset();
        keys = K_RIGHT;
        step(200);
        check_pos("dyn approach", 51, 1);
        check("dyn approach state", 32'(state), 0);
        step(1);
        check("hit state", 32'(state), 1);
        check("hit pulse", 32'(hit_pulse), 1);
        check("hit cnt", 32'(hit_cnt), 1);
        check_pos("hit respawn", 1, 1);
        dyn_x = 12'd1;
        dyn_y = 12'd1;
        step(1);
        check("hit pulse one cycle", 32'(hit_pulse), 0);
        step(8);
        dyn_x = 12'd4000;
        dyn_y = 12'd4000;
        step(6);
        check("hit last cycle state", 32'(state), 1);
        check("hit spawn overlap ignored", 32'(hit_cnt), 1);
        check_pos("hit keys ignored", 1, 1);
        step(1);
        check("respawn play", 32'(state), 0);
        step(4);
        check_pos("respawn first tick", 2, 1);

        // Reset on the hit-entry cycle and with a pending overlap leaves no pulse.
        far_away();
        rst   = 1'b1;
        keys  = K_NONE;
        dyn_x = 12'd1;
        dyn_y = 12'd1;
        step(2);
        rst = 1'b0;
        step(1);
        check("rst-hit entry", 32'(state), 1);
        check("rst-hit count", 32'(hit_cnt), 1);
        rst = 1'b1;
        step(1);
        check("rst mid-hit state", 32'(state), 0);
        check("rst mid-hit pulse", 32'(hit_pulse), 0);
        check("rst mid-hit count", 32'(hit_cnt), 0);
        step(2);
        check("rst held pulse", 32'(hit_pulse), 0);
        check("rst held state", 32'(state), 0);

        // Goal arrival at x=651 latches GOAL; keys ignored; reset clears it.
        far_away();
        do_reset();
        keys = K_DOWN;
        step(996);
        check_pos("goal approach y", 1, 250);
        keys = K_RIGHT;
        step(2600);
        check_pos("goal edge", 651, 250);
        check("goal edge state", 32'(state), 0);
        step(1);
        check("goal state", 32'(state), 2);
        check("goal mouse_en", 32'(mouse_en), 1);
        step(20);
        check_pos("goal frozen", 651, 250);
        check("goal sticky", 32'(state), 2);
        check("goal game_over", 32'(game_over), 0);
        rst = 1'b1;
        step(1);
        check("goal rst state", 32'(state), 0);
        check("goal rst mouse_en", 32'(mouse_en), 0);
        check_pos("goal rst pos", 1, 1);

        // Hit and goal in the same cycle: hit wins.
        far_away();
        dyn_x = 12'd750;
        dyn_y = 12'd250;
        do_reset();
        keys = K_DOWN;
        step(996);
        keys = K_RIGHT;
        step(2600);
        check_pos("hit+goal edge", 651, 250);
        step(1);
        check("hit+goal state", 32'(state), 1);
        check("hit+goal mouse_en", 32'(mouse_en), 0);
        check("hit+goal cnt", 32'(hit_cnt), 1);
        check_pos("hit+goal respawn", 1, 1);

`ifdef PLAYER_LIVES_EN
        // Two lives: second hit ends the game.
        far_away();
        dyn_x = 12'd1;
        dyn_y = 12'd1;
        do_reset();
        step(1);
        check("lives hit1 state", 32'(state), 1);
        check("lives hit1 game_over", 32'(game_over), 0);
        step(16);
        check("lives resume", 32'(state), 0);
        step(1);
        check("lives over state", 32'(state), 3);
        check("lives game_over", 32'(game_over), 1);
        check("lives hit_cnt", 32'(hit_cnt), 2);
        check("lives over pulse", 32'(hit_pulse), 1);
        keys = K_RIGHT;
        step(20);
        check("lives over sticky", 32'(state), 3);
        check_pos("lives frozen", 1, 1);
        check("lives cnt held", 32'(hit_cnt), 2);
`else
        // Obstacle parked on spawn: one hit every 17 clocks until the counter saturates.
        far_away();
        dyn_x = 12'd1;
        dyn_y = 12'd1;
        do_reset();
        step(1 + 17 * 9);
        check("repeat hit cnt", 32'(hit_cnt), 10);
        check("repeat hit pulse", 32'(hit_pulse), 1);
        step(17 * 300);
        check("hit_cnt saturate", 32'(hit_cnt), 255);
        check("no game_over", 32'(game_over), 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
